// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 receiver that turns make/break codes into held key levels
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk, ps2_dat    raw asynchronous PS/2 pins (device to host)
//   key_w/a/s/d/esc/enter  held levels of the game keys
//   scan_code           last good byte received
//   scan_valid          1-cycle pulse when scan_code updates
//   frame_err           1-cycle pulse on parity/stop error or mid-frame timeout
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       key_w,
  output logic       key_a,
  output logic       key_s,
  output logic       key_d,
  output logic       key_esc,
  output logic       key_enter,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t           state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic             clk_prev_q;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             brk_q, brk_d, ext_q, ext_d;
  logic [5:0]       keys_q, keys_d;
  logic [7:0]       code_q, code_d;
  logic             valid_q, valid_d, err_q, err_d;
  logic             sclk, sdat, fall;
  assign sclk = clk_sync_q[SYNC_STAGES-1];
  assign sdat = dat_sync_q[SYNC_STAGES-1];
  assign fall = clk_prev_q & ~sclk;
  // Synchronisers reset to the idle-high line level so reset itself never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      timer_q    <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      keys_q     <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
      clk_prev_q <= sclk;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      timer_q    <= timer_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      keys_q     <= keys_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    timer_d  = (state_q == IDLE || fall) ? '0 : timer_q + TW'(1);
    brk_d    = brk_q;
    ext_d    = ext_q;
    keys_d   = keys_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (state_q != IDLE && !fall && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      timer_d = '0;
      err_d   = 1'b1;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = sdat ? IDLE : DATA;
          cnt_d   = '0;
        end
        DATA: begin
          shift_d = {sdat, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          parity_d = sdat;
          state_d  = STOP;
        end
        default: begin
          state_d = IDLE;
          if (sdat && ^{shift_q, parity_q}) begin
            valid_d = 1'b1;
            code_d  = shift_q;
            if (shift_q == 8'hF0) brk_d = 1'b1;
            else if (shift_q == 8'hE0) ext_d = 1'b1;
            else begin
              // E0-prefixed codes are other physical keys (e.g. keypad ENTER) and must not alias.
              if (!ext_q) begin
                if (shift_q == 8'h1D) keys_d[0] = ~brk_q;
                if (shift_q == 8'h1C) keys_d[1] = ~brk_q;
                if (shift_q == 8'h1B) keys_d[2] = ~brk_q;
                if (shift_q == 8'h23) keys_d[3] = ~brk_q;
                if (shift_q == 8'h76) keys_d[4] = ~brk_q;
                if (shift_q == 8'h5A) keys_d[5] = ~brk_q;
              end
              brk_d = 1'b0;
              ext_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end
      endcase
    end
  end
  assign {key_enter, key_esc, key_d, key_s, key_a, key_w} = keys_q;
  assign scan_code  = code_q;
  assign scan_valid = valid_q;
  assign frame_err  = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: table-driven and randomized checks of ps2_key_decoder against a key-state model
module tb_ps2_key_decoder;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic key_w, key_a, key_s, key_d, key_esc, key_enter, scan_valid, frame_err;
  logic [7:0] scan_code;
  logic [5:0] keys;
  int tests = 0, fails = 0, nv = 0, ne = 0, both = 0;
  logic [5:0] mk;
  logic mbrk, mext;
  logic [7:0] mcode;
  typedef struct {
    logic [7:0] b;
    bit         bad;
    logic [5:0] keys;
    logic [7:0] code;
    int         v;
    int         e;
  } vec_t;
  vec_t tbl[12];
  logic [7:0] pool[9];
  ps2_key_decoder #(.TIMEOUT_CYCLES(200), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .key_w(key_w), .key_a(key_a), .key_s(key_s), .key_d(key_d),
    .key_esc(key_esc), .key_enter(key_enter),
    .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
  );
  assign keys = {key_enter, key_esc, key_d, key_s, key_a, key_w};
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (scan_valid) nv <= nv + 1;
    if (frame_err) ne <= ne + 1;
    if (scan_valid && frame_err) both <= both + 1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int key_idx(input logic [7:0] b);
    case (b)
      8'h1D: return 0;
      8'h1C: return 1;
      8'h1B: return 2;
      8'h23: return 3;
      8'h76: return 4;
      8'h5A: return 5;
      default: return -1;
    endcase
  endfunction
  task automatic model_byte(input logic [7:0] b, input bit bad);
    int k;
    if (bad) begin
      mbrk = 1'b0;
      mext = 1'b0;
      return;
    end
    mcode = b;
    k = key_idx(b);
    if (b == 8'hF0) mbrk = 1'b1;
    else if (b == 8'hE0) mext = 1'b1;
    else begin
      if (!mext && k >= 0) mk[k] = !mbrk;
      mbrk = 1'b0;
      mext = 1'b0;
    end
  endtask
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      repeat (40) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (40) @(posedge clk);
      ps2_clk = 1'b1;
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input bit bad);
    send_bits({1'b1, (~^b) ^ bad, b, 1'b0}, 11);
    ps2_dat = 1'b1;
    repeat (100) @(posedge clk);
  endtask
  task automatic run_frame(input string name, input logic [7:0] b, input bit bad);
    int v0, e0;
    v0 = nv;
    e0 = ne;
    send_frame(b, bad);
    model_byte(b, bad);
    @(negedge clk);
    check({name, "_keys"}, 32'(keys), 32'(mk));
    check({name, "_code"}, 32'(scan_code), 32'(mcode));
    check({name, "_valid"}, nv - v0, bad ? 0 : 1);
    check({name, "_err"}, ne - e0, bad ? 1 : 0);
  endtask
  initial begin
    int v0, e0, p;
    logic [7:0] b;
    tbl[0]  = '{8'h1D, 1'b0, 6'b000001, 8'h1D, 1, 0};
    tbl[1]  = '{8'hF0, 1'b0, 6'b000001, 8'hF0, 1, 0};
    tbl[2]  = '{8'h1D, 1'b0, 6'b000000, 8'h1D, 1, 0};
    tbl[3]  = '{8'h1C, 1'b1, 6'b000000, 8'h1D, 0, 1};
    tbl[4]  = '{8'h1C, 1'b0, 6'b000010, 8'h1C, 1, 0};
    tbl[5]  = '{8'hE0, 1'b0, 6'b000010, 8'hE0, 1, 0};
    tbl[6]  = '{8'h5A, 1'b0, 6'b000010, 8'h5A, 1, 0};
    tbl[7]  = '{8'h5A, 1'b0, 6'b100010, 8'h5A, 1, 0};
    tbl[8]  = '{8'hE0, 1'b0, 6'b100010, 8'hE0, 1, 0};
    tbl[9]  = '{8'hF0, 1'b0, 6'b100010, 8'hF0, 1, 0};
    tbl[10] = '{8'h5A, 1'b0, 6'b100010, 8'h5A, 1, 0};
    tbl[11] = '{8'hAA, 1'b0, 6'b100010, 8'hAA, 1, 0};
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h76, 8'h5A, 8'hF0, 8'hE0, 8'hAA};
    mk = '0; mbrk = 1'b0; mext = 1'b0; mcode = '0;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_keys", 32'(keys), 0);
    check("reset_code", 32'(scan_code), 0);
    check("reset_pulses", {30'd0, scan_valid, frame_err}, 0);
    for (int i = 0; i < 12; i++) begin
      v0 = nv;
      e0 = ne;
      send_frame(tbl[i].b, tbl[i].bad);
      model_byte(tbl[i].b, tbl[i].bad);
      @(negedge clk);
      check($sformatf("tbl%0d_keys", i), 32'(keys), 32'(tbl[i].keys));
      check($sformatf("tbl%0d_code", i), 32'(scan_code), 32'(tbl[i].code));
      check($sformatf("tbl%0d_valid", i), nv - v0, tbl[i].v);
      check($sformatf("tbl%0d_err", i), ne - e0, tbl[i].e);
    end
    v0 = nv;
    e0 = ne;
    send_bits({6'b111111, 4'b0110, 1'b0}, 5);
    ps2_dat = 1'b1;
    repeat (250) @(posedge clk);
    model_byte(8'h00, 1'b1);
    @(negedge clk);
    check("timeout_err", ne - e0, 1);
    check("timeout_valid", nv - v0, 0);
    check("timeout_code", 32'(scan_code), 32'(mcode));
    run_frame("esc", 8'h76, 1'b0);
    check("esc_level", 32'(key_esc), 1);
    run_frame("press_w", 8'h1D, 1'b0);
    run_frame("press_a", 8'h1C, 1'b0);
    run_frame("press_d", 8'h23, 1'b0);
    send_bits({7'b1111111, 3'b101, 1'b0}, 4);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_keys", 32'(keys), 0);
    check("rst_code", 32'(scan_code), 0);
    mk = '0; mbrk = 1'b0; mext = 1'b0; mcode = '0;
    ps2_dat = 1'b1;
    repeat (300) @(posedge clk);
    run_frame("after_rst_d", 8'h23, 1'b0);
    check("after_rst_dlevel", 32'(key_d), 1);
    for (int i = 0; i < 30; i++) begin
      p = $urandom_range(0, 9);
      b = (p == 9) ? 8'($urandom_range(0, 255)) : pool[p];
      run_frame($sformatf("rnd%0d", i), b, $urandom_range(0, 7) == 0);
    end
    check("valid_err_exclusive", both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
